// File: rtl/ecc_ladder_core.sv
// Montgomery-ladder scalar multiplier over GF(2^M) using Lopez-Dahab x-only coordinates.
// Runs exactly KW steps per start, regardless of the scalar's value, and outputs (k.P, (k+1).P).
module ecc_ladder_core #(
  parameter int              M    = 163,
  parameter logic [M-1:0]    POLY = 'hC9,
  parameter int              KW   = 163,
  parameter int              CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [M-1:0]  xp,
  input  logic [M-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic [M-1:0]  x1,
  output logic [M-1:0]  z1,
  output logic [M-1:0]  x2,
  output logic [M-1:0]  z2
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  // Reduce a raw product of degree <= 2M-2 by x^M + POLY.
  function automatic logic [M-1:0] gf_reduce(input logic [2*M-2:0] raw);
    logic [2*M-2:0] t;
    t = raw;
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        t[i-M +: M] = t[i-M +: M] ^ POLY;
      end
    end
    return t[M-1:0];
  endfunction

  // Interleaved shift-and-add multiplication, reducing as each bit is consumed.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] c);
    logic [M-1:0] r;
    r = '0;
    for (int i = M-1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
      if (c[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Squaring in characteristic 2 only spreads the bits out before reduction.
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = a[i];
    return gf_reduce(t);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [M-1:0]  xp_q, xp_d;
  logic [M-1:0]  b_q, b_d;
  logic [M-1:0]  x1_q, x1_d;
  logic [M-1:0]  z1_q, z1_d;
  logic [M-1:0]  x2_q, x2_d;
  logic [M-1:0]  z2_q, z2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;

  logic          bit_i;
  logic [M-1:0]  a_prod, b_prod;
  logic [M-1:0]  za, xa;
  logic [M-1:0]  dbl_x, dbl_z, x_sq, z_sq;
  logic [M-1:0]  xd, zd;

  // Both ladder formulas are evaluated every cycle; the scalar bit only steers the results.
  always_comb begin
    bit_i  = k_q[cnt_q];
    a_prod = gf_mul(x1_q, z2_q);
    b_prod = gf_mul(x2_q, z1_q);
    za     = gf_sqr(a_prod ^ b_prod);
    xa     = gf_mul(xp_q, za) ^ gf_mul(a_prod, b_prod);
    dbl_x  = bit_i ? x2_q : x1_q;
    dbl_z  = bit_i ? z2_q : z1_q;
    x_sq   = gf_sqr(dbl_x);
    z_sq   = gf_sqr(dbl_z);
    xd     = gf_sqr(x_sq) ^ gf_mul(b_q, gf_sqr(z_sq));
    zd     = gf_mul(x_sq, z_sq);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    xp_d    = xp_q;
    b_d     = b_q;
    x1_d    = x1_q;
    z1_d    = z1_q;
    x2_d    = x2_q;
    z2_d    = z2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          xp_d    = xp;
          b_d     = b;
          x1_d    = ONE;
          z1_d    = '0;
          x2_d    = xp;
          z2_d    = ONE;
          cnt_d   = CW'(KW-1);
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bit_i) begin
          x1_d = xa;
          z1_d = za;
          x2_d = xd;
          z2_d = zd;
        end else begin
          x2_d = xa;
          z2_d = za;
          x1_d = xd;
          z1_d = zd;
        end
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      xp_q    <= '0;
      b_q     <= '0;
      x1_q    <= ONE;
      z1_q    <= '0;
      x2_q    <= '0;
      z2_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      xp_q    <= xp_d;
      b_q     <= b_d;
      x1_q    <= x1_d;
      z1_q    <= z1_d;
      x2_q    <= x2_d;
      z2_q    <= z2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign x1    = x1_q;
  assign z1    = z1_q;
  assign x2    = x2_q;
  assign z2    = z2_q;

endmodule

// File: tb/tb_ecc_ladder_core.sv
// Directed bench for ecc_ladder_core: fixed scalars, a reference ladder built on a
// schoolbook multiplier, operand changes mid-run and a reset that aborts a run.
module tb_ecc_ladder_core;

  localparam int           M    = 163;
  localparam int           KW   = 163;
  localparam int           CW   = 8;
  localparam logic [M-1:0] POLY = 163'hC9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k;
  logic [M-1:0]  xp;
  logic [M-1:0]  b;
  logic          busy;
  logic          done;
  logic          valid;
  logic [M-1:0]  x1;
  logic [M-1:0]  z1;
  logic [M-1:0]  x2;
  logic [M-1:0]  z2;

  int checkCount = 0;
  int errorCount = 0;

  ecc_ladder_core #(.M(M), .POLY(POLY), .KW(KW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .xp(xp), .b(b),
    .busy(busy), .done(done), .valid(valid),
    .x1(x1), .z1(z1), .x2(x2), .z2(z2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Full polynomial product followed by long division by x^M + POLY.
  function automatic logic [M-1:0] fieldMul(input logic [M-1:0] a, input logic [M-1:0] c);
    logic [2*M-2:0] p;
    logic [2*M-2:0] red;
    p   = '0;
    red = {{(M-2){1'b0}}, 1'b1, POLY};
    for (int i = 0; i < M; i++)
      if (c[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (red << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] fieldSqr(input logic [M-1:0] a);
    return fieldMul(a, a);
  endfunction

  function automatic logic [M-1:0] rndField();
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[M-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic modelLadder(input logic [KW-1:0] kv, input logic [M-1:0] xv, input logic [M-1:0] bv,
                             output logic [M-1:0] ox1, output logic [M-1:0] oz1,
                             output logic [M-1:0] ox2, output logic [M-1:0] oz2);
    logic [M-1:0] px1, pz1, px2, pz2, ma, mb, za, xa, dx, dz, xd, zd;
    px1 = M'(1); pz1 = '0; px2 = xv; pz2 = M'(1);
    for (int i = KW-1; i >= 0; i--) begin
      ma = fieldMul(px1, pz2);
      mb = fieldMul(px2, pz1);
      za = fieldSqr(ma ^ mb);
      xa = fieldMul(xv, za) ^ fieldMul(ma, mb);
      dx = kv[i] ? px2 : px1;
      dz = kv[i] ? pz2 : pz1;
      xd = fieldSqr(fieldSqr(dx)) ^ fieldMul(bv, fieldSqr(fieldSqr(dz)));
      zd = fieldMul(fieldSqr(dx), fieldSqr(dz));
      if (kv[i]) begin
        px1 = xa; pz1 = za; px2 = xd; pz2 = zd;
      end else begin
        px2 = xa; pz2 = za; px1 = xd; pz1 = zd;
      end
    end
    ox1 = px1; oz1 = pz1; ox2 = px2; oz2 = pz2;
  endtask

  // One full operation; with disturb set, start and the operand inputs are scrambled during RUN.
  task automatic applyStimulus(input logic [KW-1:0] kv, input logic [M-1:0] xv, input logic [M-1:0] bv,
                               input bit disturb, input string tag);
    logic [M-1:0] ex1, ez1, ex2, ez2;
    int edges;
    bit seen;
    modelLadder(kv, xv, bv, ex1, ez1, ex2, ez2);
    @(negedge clk);
    start = 1'b1; k = kv; xp = xv; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy_run"}, M'(busy), M'(1));
    checkOutput({tag, "_valid_run"}, M'(valid), M'(0));
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < KW + 10) begin
      @(posedge clk); edges++; #1;
      if (done) seen = 1'b1;
      else if (disturb) begin
        start = (edges < KW - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        k  = {rndField()};
        xp = rndField();
        b  = rndField();
      end
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, M'(edges), M'(KW + 1));
    checkOutput({tag, "_busy_done"}, M'(busy), M'(0));
    checkOutput({tag, "_valid"}, M'(valid), M'(1));
    checkOutput({tag, "_x1"}, x1, ex1);
    checkOutput({tag, "_z1"}, z1, ez1);
    checkOutput({tag, "_x2"}, x2, ex2);
    checkOutput({tag, "_z2"}, z2, ez2);
    @(posedge clk); #1;
    checkOutput({tag, "_done_drop"}, M'(done), M'(0));
    checkOutput({tag, "_valid_hold"}, M'(valid), M'(1));
    checkOutput({tag, "_x1_hold"}, x1, ex1);
  endtask

  initial begin
    logic [M-1:0] xv, bv;
    int guard;
    rst_n = 1'b0; start = 1'b0; k = '0; xp = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", M'(busy), M'(0));
    checkOutput("rst_done", M'(done), M'(0));
    checkOutput("rst_valid", M'(valid), M'(0));
    checkOutput("rst_x1", x1, M'(1));
    checkOutput("rst_z1", z1, M'(0));
    checkOutput("rst_x2", x2, M'(0));
    checkOutput("rst_z2", z2, M'(0));
    @(negedge clk); rst_n = 1'b1;

    // k = 0: the ladder never leaves (infinity, P).
    xv = 163'h2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8;
    bv = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;
    applyStimulus('0, xv, bv, 1'b0, "k0");
    checkOutput("k0_x1_const", x1, M'(1));
    checkOutput("k0_z1_const", z1, M'(0));
    checkOutput("k0_x2_const", x2, xv);
    checkOutput("k0_z2_const", z2, M'(1));

    // k = 1: (P, 2P) with 2P = (xp^4 + b, xp^2).
    applyStimulus(KW'(1), xv, bv, 1'b0, "k1");
    checkOutput("k1_x1_direct", x1, xv);
    checkOutput("k1_z1_direct", z1, M'(1));
    checkOutput("k1_x2_direct", x2, fieldSqr(fieldSqr(xv)) ^ bv);
    checkOutput("k1_z2_direct", z2, fieldSqr(xv));

    // k = 2: x1/z1 must satisfy the affine doubling relation X = x(2P)^... i.e. X = xp^2*Z + b.
    applyStimulus(KW'(2), xv, bv, 1'b0, "k2");
    checkOutput("k2_x1_direct", x1, fieldSqr(fieldSqr(xv)) ^ bv);
    checkOutput("k2_z1_direct", z1, fieldSqr(xv));
    checkOutput("k2_affine_2p", x1, fieldMul(fieldSqr(xv), z1) ^ bv);

    applyStimulus('1, rndField(), rndField(), 1'b0, "kones");
    applyStimulus({1'b1, {(KW-1){1'b0}}}, rndField(), rndField(), 1'b0, "kmsb");

    for (int i = 0; i < 50; i++)
      applyStimulus(rndField(), rndField(), rndField(), 1'b0, $sformatf("rnd%0d", i));

    applyStimulus(rndField(), rndField(), rndField(), 1'b1, "disturb");
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("disturb_no_extra_done", M'(done), M'(0));
    end

    // Reset asserted at step 40 of a run aborts it immediately.
    @(negedge clk);
    start = 1'b1; k = rndField(); xp = rndField(); b = rndField();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", M'(busy), M'(0));
    checkOutput("abort_done", M'(done), M'(0));
    checkOutput("abort_valid", M'(valid), M'(0));
    checkOutput("abort_x1", x1, M'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    repeat (KW + 5) begin
      @(posedge clk); #1;
      if (done) guard++;
    end
    checkOutput("abort_no_done", M'(guard), M'(0));
    checkOutput("abort_valid_after", M'(valid), M'(0));
    applyStimulus(rndField(), rndField(), rndField(), 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
